// File: rtl/ms_timer_sched.sv
// ms_timer_sched: multi-channel millisecond timeout scheduler.
// A shared prescaler produces a millisecond tick that advances ms_cnt. Requesters
// arm one-shot timeouts through a round-robin req/ack arbiter, and each channel
// compares its stored deadline against the shared count.
//
// Channel FSM (one per channel)
//   state | meaning
//   IDLE  | no pending timeout, busy=0
//   ARMED | deadline loaded, waiting for ms_cnt to reach it, busy=1
module ms_timer_sched #(
  parameter int NCH        = 4,
  parameter int CLK_PER_MS = 1000,
  parameter int W          = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic [NCH-1:0]    arm_req_i,
  input  logic [NCH*16-1:0] arm_ms_i,
  input  logic [NCH-1:0]    cancel_i,
  output logic [NCH-1:0]    arm_ack_o,
  output logic [NCH-1:0]    busy_o,
  output logic [NCH-1:0]    expire_o,
  output logic              ms_tick_o,
  output logic [W-1:0]      ms_cnt_o
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int RW = $clog2(NCH);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [RW-1:0] RR_LAST  = RW'(NCH - 1);
  localparam logic IDLE  = 1'b0;
  localparam logic ARMED = 1'b1;

  logic [PW-1:0]         pre_q, pre_d;
  logic [W-1:0]          ms_cnt_q, ms_cnt_d, ms_cnt_inc;
  logic                  tick;
  logic [RW-1:0]         rr_q, rr_d, gnt_idx;
  logic                  gnt_vld;
  logic [NCH-1:0]        elig, grant;
  logic [NCH-1:0]        state_q, state_d;
  logic [NCH-1:0]        expire_q, expire_d;
  logic [NCH-1:0][W-1:0] dl_q, dl_d;

  assign tick       = en_i && (pre_q == PRE_LAST);
  assign ms_cnt_inc = ms_cnt_q + W'(1);
  // A cancelled channel never competes for the grant in the same cycle.
  assign elig       = arm_req_i & ~cancel_i;

  // Timebase: prescaler wraps on the tick, ms counter advances with it.
  always_comb begin
    pre_d    = pre_q;
    ms_cnt_d = ms_cnt_q;
    if (en_i) begin
      if (tick) begin
        pre_d    = '0;
        ms_cnt_d = ms_cnt_inc;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  // Round-robin arbiter: first eligible channel at or after rr, wrapping.
  always_comb begin
    int idx;
    grant   = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr_q) + k) % NCH;
      if (!gnt_vld && elig[idx[RW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx[RW-1:0];
      end
    end
    if (gnt_vld) grant[gnt_idx] = 1'b1;
    rr_d = rr_q;
    if (gnt_vld) rr_d = (gnt_idx == RR_LAST) ? '0 : gnt_idx + RW'(1);
  end

  // Channel next state: cancel > grant (arm / re-arm / zero delay) > deadline hit.
  always_comb begin
    state_d  = state_q;
    dl_d     = dl_q;
    expire_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cancel_i[i]) begin
        state_d[i] = IDLE;
      end else if (grant[i]) begin
        if (arm_ms_i[16*i +: 16] == 16'd0) begin
          state_d[i]  = IDLE;
          expire_d[i] = 1'b1;
        end else begin
          state_d[i] = ARMED;
          dl_d[i]    = ms_cnt_q + W'(arm_ms_i[16*i +: 16]);
        end
      end else if (state_q[i] == ARMED && tick && ms_cnt_inc == dl_q[i]) begin
        state_d[i]  = IDLE;
        expire_d[i] = 1'b1;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      pre_q    <= '0;
      ms_cnt_q <= '0;
      rr_q     <= '0;
      state_q  <= '0;
      expire_q <= '0;
      dl_q     <= '0;
    end else begin
      pre_q    <= pre_d;
      ms_cnt_q <= ms_cnt_d;
      rr_q     <= rr_d;
      state_q  <= state_d;
      expire_q <= expire_d;
      dl_q     <= dl_d;
    end
  end

  // Outputs; the grant is suppressed while reset is held.
  always_comb begin
    arm_ack_o = reset_i ? grant : '0;
    busy_o    = state_q;
    expire_o  = expire_q;
    ms_tick_o = tick;
    ms_cnt_o  = ms_cnt_q;
  end

endmodule

// File: tb/tb_ms_timer_sched.sv
// Testbench for ms_timer_sched: directed vector table, hand-written corner
// sequences and a randomized run against a cycle-level behavioural model.
module tb_ms_timer_sched;
  localparam int CPM = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, en;
  logic [3:0]  req, cancel;
  logic [63:0] arm_ms;
  logic [3:0]  ack, busy, expire;
  logic        tick;
  logic [31:0] ms;

  logic        reset2, en2;
  logic [1:0]  req2, cancel2;
  logic [31:0] arm_ms2;
  logic [1:0]  ack2, busy2, exp2;
  logic        tick2;
  logic [16:0] ms2;

  ms_timer_sched #(.NCH(4), .CLK_PER_MS(CPM), .W(32)) dut (
    .clk_i(clk), .reset_i(reset_n), .en_i(en), .arm_req_i(req), .arm_ms_i(arm_ms),
    .cancel_i(cancel), .arm_ack_o(ack), .busy_o(busy), .expire_o(expire),
    .ms_tick_o(tick), .ms_cnt_o(ms));

  ms_timer_sched #(.NCH(2), .CLK_PER_MS(2), .W(17)) dut2 (
    .clk_i(clk), .reset_i(reset2), .en_i(en2), .arm_req_i(req2), .arm_ms_i(arm_ms2),
    .cancel_i(cancel2), .arm_ack_o(ack2), .busy_o(busy2), .expire_o(exp2),
    .ms_tick_o(tick2), .ms_cnt_o(ms2));

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model: absolute deadlines per channel, a phase counter for the
  // prescaler and a rotating priority pointer.
  int          m_pre;
  logic [31:0] m_ms;
  int          m_rr;
  logic [3:0]  m_busy, m_exp;
  logic [31:0] m_dl [4];

  task automatic model_reset();
    m_pre = 0; m_ms = '0; m_rr = 0; m_busy = '0; m_exp = '0;
    for (int i = 0; i < 4; i++) m_dl[i] = '0;
  endtask

  function automatic logic [3:0] m_ack();
    logic [3:0] g;
    g = '0;
    if (reset_n) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_rr + k) % 4;
        if (g == 4'd0 && req[c] && !cancel[c]) g[c] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic model_check();
    check("ack", ack, m_ack());
    check("busy", busy, m_busy);
    check("expire", expire, m_exp);
    check("tick", tick, en && (m_pre == CPM - 1));
    check("ms_cnt", ms, m_ms);
  endtask

  task automatic model_step();
    logic [3:0]  g;
    logic        t;
    logic [31:0] nms;
    logic [15:0] d;
    if (!reset_n) begin
      model_reset();
      return;
    end
    g   = m_ack();
    t   = en && (m_pre == CPM - 1);
    nms = t ? m_ms + 32'd1 : m_ms;
    for (int i = 0; i < 4; i++) begin
      d = arm_ms[16*i +: 16];
      m_exp[i] = 1'b0;
      if (cancel[i]) m_busy[i] = 1'b0;
      else if (g[i]) begin
        if (d == 16'd0) begin m_busy[i] = 1'b0; m_exp[i] = 1'b1; end
        else begin m_busy[i] = 1'b1; m_dl[i] = m_ms + 32'(d); end
      end else if (m_busy[i] && t && nms == m_dl[i]) begin
        m_busy[i] = 1'b0; m_exp[i] = 1'b1;
      end
      if (g[i]) m_rr = (i + 1) % 4;
    end
    if (en) m_pre = t ? 0 : m_pre + 1;
    m_ms = nms;
  endtask

  // One clock: compare against the model, advance it, move to the next negedge.
  task automatic cycle();
    #1;
    model_check();
    model_step();
    @(negedge clk);
  endtask

  task automatic set_d(input int ch, input logic [15:0] d);
    arm_ms[16*ch +: 16] = d;
  endtask

  task automatic do_reset();
    req = '0; cancel = '0; en = 1'b1;
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] d;
    logic [3:0]  ack;
    logic [3:0]  busy;
    logic        tick;
  } vec_t;
  vec_t tbl [7];

  int          n_exp, cnt;
  logic [31:0] exp_ms, hold_ms;
  logic        found, ok_frozen, saw_zero;
  logic [3:0]  last_ack;

  initial begin
    tbl[0] = '{4'b1111, 16'd10, 4'b0001, 4'b0000, 1'b0};
    tbl[1] = '{4'b1110, 16'd10, 4'b0010, 4'b0001, 1'b0};
    tbl[2] = '{4'b1100, 16'd10, 4'b0100, 4'b0011, 1'b0};
    tbl[3] = '{4'b1000, 16'd10, 4'b1000, 4'b0111, 1'b1};
    tbl[4] = '{4'b0101, 16'd10, 4'b0001, 4'b1111, 1'b0};
    tbl[5] = '{4'b0100, 16'd10, 4'b0100, 4'b1111, 1'b0};
    tbl[6] = '{4'b0000, 16'd10, 4'b0000, 4'b1111, 1'b0};

    reset2 = 1'b0; en2 = 1'b0; req2 = '0; cancel2 = '0; arm_ms2 = '0;
    reset_n = 1'b0; en = 1'b1; req = 4'b1111; cancel = '0; arm_ms = '0;
    repeat (2) @(negedge clk);
    #1 check("ack_in_reset", ack, 4'b0000);
    check("reset_busy", busy, 4'b0000);
    check("reset_expire", expire, 4'b0000);
    check("reset_ms", ms, 32'd0);
    req = '0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Basic expiry: arm ch0 D=3 at ms 0.
    do_reset();
    req = 4'b0001; set_d(0, 16'd3);
    #1 check("basic_ack", ack, 4'b0001);
    cycle();
    req = '0;
    #1 check("basic_busy", busy[0], 1'b1);
    n_exp = 0; exp_ms = '0;
    for (int c = 0; c < 30; c++) begin
      #1 if (expire[0]) begin n_exp++; exp_ms = ms; end
      cycle();
    end
    check("basic_expire_count", n_exp, 1);
    check("basic_expire_ms", exp_ms, 3);
    check("basic_idle_after", busy[0], 1'b0);

    // Round-robin vector table.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      req = tbl[i].req; cancel = '0; arm_ms = {4{tbl[i].d}};
      #1;
      check($sformatf("rr_ack[%0d]", i), ack, tbl[i].ack);
      check($sformatf("rr_busy[%0d]", i), busy, tbl[i].busy);
      check($sformatf("rr_tick[%0d]", i), tick, tbl[i].tick);
      cycle();
    end
    cancel = 4'b1111;
    cycle();
    cancel = '0;

    // Cancel in the same cycle the deadline would hit.
    do_reset();
    req = 4'b0010; set_d(1, 16'd2);
    cycle();
    req = '0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      #1 if (tick && ms == 32'd1) found = 1'b1;
      else cycle();
    end
    check("cancel_hit_found", found, 1'b1);
    cancel = 4'b0010;
    cycle();
    cancel = '0;
    #1 check("cancel_no_expire", expire[1], 1'b0);
    check("cancel_idle", busy[1], 1'b0);
    req = 4'b0100; cancel = 4'b0100; set_d(2, 16'd3);
    #1 check("cancel_masks_ack", ack, 4'b0000);
    cycle();
    req = '0; cancel = '0;
    #1 check("cancel_req_idle", busy[2], 1'b0);
    cycle();

    // Re-arm ch3 at ms 2 with D=4, then zero-delay arm on ch0.
    do_reset();
    req = 4'b1000; set_d(3, 16'd5);
    cycle();
    req = '0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      #1 if (ms == 32'd2) found = 1'b1;
      else cycle();
    end
    check("rearm_reach_2", found, 1'b1);
    req = 4'b1000; set_d(3, 16'd4);
    cycle();
    req = '0;
    n_exp = 0; exp_ms = '0;
    for (int c = 0; c < 40; c++) begin
      #1 if (expire[3]) begin n_exp++; exp_ms = ms; end
      cycle();
    end
    check("rearm_expire_count", n_exp, 1);
    check("rearm_expire_ms", exp_ms, 6);
    req = 4'b0001; set_d(0, 16'd0);
    #1 check("d0_ack", ack, 4'b0001);
    cycle();
    req = '0;
    #1 check("d0_expire", expire[0], 1'b1);
    check("d0_busy", busy[0], 1'b0);
    cycle();
    #1 check("d0_expire_single", expire[0], 1'b0);
    check("d0_busy_after", busy[0], 1'b0);

    // Timebase freeze with ch0 armed.
    do_reset();
    req = 4'b0001; set_d(0, 16'd2);
    cycle();
    req = '0; en = 1'b0;
    #1 hold_ms = ms;
    ok_frozen = 1'b1; n_exp = 0;
    for (int c = 0; c < 20; c++) begin
      #1 if (ms != hold_ms || tick) ok_frozen = 1'b0;
      if (expire[0]) n_exp++;
      cycle();
    end
    check("en_frozen", ok_frozen, 1'b1);
    check("en_no_expire", n_exp, 0);
    check("en_still_busy", busy[0], 1'b1);
    en = 1'b1;
    n_exp = 0; exp_ms = '0;
    for (int c = 0; c < 30; c++) begin
      #1 if (expire[0]) begin n_exp++; exp_ms = ms; end
      cycle();
    end
    check("en_resume_count", n_exp, 1);
    check("en_resume_ms", exp_ms, 2);

    // Reset with ch1 armed drops it silently.
    req = 4'b0010; set_d(1, 16'd50);
    cycle();
    req = '0;
    repeat (3) cycle();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    #1 check("rst_busy", busy, 4'b0000);
    check("rst_ms", ms, 32'd0);
    n_exp = 0;
    for (int c = 0; c < 250; c++) begin
      #1 if (expire != 4'b0000) n_exp++;
      cycle();
    end
    check("rst_no_expire", n_exp, 0);

    // Randomized traffic against the model.
    do_reset();
    last_ack = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (req[i] && last_ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(5) == 0) begin
          req[i] = 1'b1;
          set_d(i, 16'($urandom_range(6)));
        end
        cancel[i] = ($urandom_range(19) == 0);
      end
      en = ($urandom_range(9) != 0);
      reset_n = ($urandom_range(499) != 0);
      #1 last_ack = ack;
      cycle();
    end
    reset_n = 1'b1; req = '0; cancel = '0;

    // Counter wrap on the 17-bit instance, preloaded near the top.
    reset2 = 1'b1;
    force dut2.ms_cnt_q = 17'h1FFFE;
    @(negedge clk);
    release dut2.ms_cnt_q;
    #1 check("wrap_preload", ms2, 17'h1FFFE);
    check("wrap_no_tick_when_off", tick2, 1'b0);
    en2 = 1'b1; req2 = 2'b01; arm_ms2[15:0] = 16'd5;
    #1 check("wrap_ack", ack2, 2'b01);
    @(negedge clk);
    req2 = '0;
    n_exp = 0; exp_ms = '0; saw_zero = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1 if (exp2[0]) begin n_exp++; exp_ms = 32'(ms2); end
      if (ms2 == 17'd0) saw_zero = 1'b1;
      @(negedge clk);
    end
    check("wrap_seen_zero", saw_zero, 1'b1);
    check("wrap_expire_count", n_exp, 1);
    check("wrap_expire_ms", exp_ms, 3);
    check("wrap_idle", busy2[0], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial cnt = 0;
endmodule
